// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (IFU) and the load/store unit (LSU).
// One transaction in flight at a time, round-robin grant, watchdog turns a hung access into an error response.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   output logic [DATA_W-1:0] ifu_resp_data,
   output logic              ifu_resp_err,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [7:0]        lsu_wmask,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_resp_data,
   output logic              lsu_resp_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_rdata
);

   // state   | meaning
   // S_IDLE  | no transaction; arbitrate and accept one request
   // S_ISSUE | mem_req_valid high, waiting for mem_req_ready
   // S_WAIT  | request taken downstream, waiting for mem_resp_valid
   // S_RESP  | one-cycle response strobe to the owner
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam int            CW        = $clog2(TIMEOUT);
   localparam logic [CW-1:0] WDOG_LOAD = CW'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [7:0]        wmask_q, wmask_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [CW-1:0]     wdog_q, wdog_d;

   logic grant_lsu;
   logic grant_any;
   logic wdog_exp;
   logic ifu_sel;
   logic lsu_sel;

   // owner/last encoding: 0 = IFU, 1 = LSU
   assign grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_q);
   assign grant_any = ifu_req_valid | lsu_req_valid;
   assign wdog_exp  = (wdog_q == '0);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wen_d   = wen_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      wdog_d  = wdog_q;
      case (state_q)
         S_IDLE: begin
            if (grant_any) begin
               owner_d = grant_lsu;
               last_d  = grant_lsu;
               addr_d  = grant_lsu ? lsu_addr : ifu_addr;
               wen_d   = grant_lsu & lsu_wen;
               wdata_d = grant_lsu ? lsu_wdata : '0;
               wmask_d = grant_lsu ? lsu_wmask : '0;
               wdog_d  = WDOG_LOAD;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // saturates so a handshake on the last watchdog cycle still times out in WAIT
            wdog_d = wdog_exp ? wdog_q : wdog_q - CW'(1);
            if (mem_req_ready) begin
               state_d = S_WAIT;
            end else if (wdog_exp) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_WAIT: begin
            wdog_d = wdog_exp ? wdog_q : wdog_q - CW'(1);
            if (mem_resp_valid) begin
               rdata_d = wen_q ? '0 : mem_rdata;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (wdog_exp) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         wdog_q  <= wdog_d;
      end
   end

   // ready is gated by rst so nothing is acknowledged while reset is held
   assign ifu_req_ready = rst & (state_q == S_IDLE) & ifu_req_valid & ~grant_lsu;
   assign lsu_req_ready = rst & (state_q == S_IDLE) & grant_lsu;

   assign mem_req_valid = (state_q == S_ISSUE);
   assign mem_addr      = addr_q;
   assign mem_wen       = wen_q;
   assign mem_wdata     = wdata_q;
   assign mem_wmask     = wmask_q;

   assign ifu_sel        = (state_q == S_RESP) & ~owner_q;
   assign lsu_sel        = (state_q == S_RESP) & owner_q;
   assign ifu_resp_valid = ifu_sel;
   assign ifu_resp_data  = ifu_sel ? rdata_q : '0;
   assign ifu_resp_err   = ifu_sel & err_q;
   assign lsu_resp_valid = lsu_sel;
   assign lsu_resp_data  = lsu_sel ? rdata_q : '0;
   assign lsu_resp_err   = lsu_sel & err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked cycle by cycle
// against a transaction-age reference model.
module tb_mem_arbiter;

   localparam int TMO = 8;

   logic        clk;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready;
   logic [31:0] ifu_addr;
   logic        ifu_resp_valid;
   logic [31:0] ifu_resp_data;
   logic        ifu_resp_err;
   logic        lsu_req_valid, lsu_req_ready;
   logic [31:0] lsu_addr;
   logic        lsu_wen;
   logic [31:0] lsu_wdata;
   logic [7:0]  lsu_wmask;
   logic        lsu_resp_valid;
   logic [31:0] lsu_resp_data;
   logic        lsu_resp_err;
   logic        mem_req_valid, mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: one transaction described by owner, latched fields and its age since issue
   logic        m_busy, m_done, m_pend, m_last, m_own, m_wen, m_err;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [7:0]  m_wmask;
   int          m_age;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_done = 0; m_pend = 0; m_last = 1; m_own = 0;
      m_age = 0; m_err = 0; m_rdata = '0;
   endtask

   task automatic finish_txn(input logic [31:0] data, input logic err);
      m_busy  = 0;
      m_pend  = 1;
      m_rdata = data;
      m_err   = err;
   endtask

   // check this cycle's outputs at the falling edge, advance the model, return at posedge+1
   task automatic cycle();
      logic        idle, g_lsu, e_iv, e_lv;
      @(negedge clk);
      if (!rst) begin
         model_reset();
         chk("rst_ifu_rdy", ifu_req_ready, 0);
         chk("rst_lsu_rdy", lsu_req_ready, 0);
         chk("rst_mreq", mem_req_valid, 0);
         chk("rst_maddr", mem_addr, 0);
         chk("rst_mwen", mem_wen, 0);
         chk("rst_mwdata", mem_wdata, 0);
         chk("rst_mwmask", mem_wmask, 0);
         chk("rst_iresp", {ifu_resp_valid, ifu_resp_err, ifu_resp_data}, 0);
         chk("rst_lresp", {lsu_resp_valid, lsu_resp_err, lsu_resp_data}, 0);
      end else begin
         idle  = !m_busy && !m_pend;
         g_lsu = lsu_req_valid && (!ifu_req_valid || !m_last);
         chk("ifu_rdy", ifu_req_ready, idle && ifu_req_valid && !g_lsu);
         chk("lsu_rdy", lsu_req_ready, idle && g_lsu);
         chk("mreq", mem_req_valid, m_busy && !m_done);
         if (m_busy) begin
            chk("maddr", mem_addr, m_addr);
            chk("mwen", mem_wen, m_wen);
            chk("mwmask", mem_wmask, m_wmask);
            if (m_own) chk("mwdata", mem_wdata, m_wdata);
         end
         e_iv = m_pend && !m_own;
         e_lv = m_pend && m_own;
         chk("iresp_v", ifu_resp_valid, e_iv);
         chk("iresp_d", ifu_resp_data, e_iv ? m_rdata : 32'h0);
         chk("iresp_e", ifu_resp_err, e_iv && m_err);
         chk("lresp_v", lsu_resp_valid, e_lv);
         chk("lresp_d", lsu_resp_data, e_lv ? m_rdata : 32'h0);
         chk("lresp_e", lsu_resp_err, e_lv && m_err);
         if (m_pend) begin
            m_pend = 0;
         end else if (m_busy) begin
            if (!m_done) begin
               if (mem_req_ready) m_done = 1;
               else if (m_age >= TMO - 1) finish_txn(32'h0, 1'b1);
            end else begin
               if (mem_resp_valid) finish_txn(m_wen ? 32'h0 : mem_rdata, 1'b0);
               else if (m_age >= TMO - 1) finish_txn(32'h0, 1'b1);
            end
            m_age++;
         end else if (ifu_req_valid || lsu_req_valid) begin
            m_busy  = 1;
            m_done  = 0;
            m_age   = 0;
            m_own   = g_lsu;
            m_last  = g_lsu;
            m_addr  = g_lsu ? lsu_addr : ifu_addr;
            m_wen   = g_lsu && lsu_wen;
            m_wdata = lsu_wdata;
            m_wmask = g_lsu ? lsu_wmask : 8'h0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic quiet(input int n);
      ifu_req_valid = 0; lsu_req_valid = 0;
      mem_req_ready = 0; mem_resp_valid = 0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   int   grants[$];
   int   cnt;
   int   lat;
   logic found;

   initial begin
      rst = 0;
      ifu_req_valid = 1; lsu_req_valid = 1;
      ifu_addr = 32'h0; lsu_addr = 32'h0; lsu_wen = 0; lsu_wdata = 32'h0; lsu_wmask = 8'h0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 32'h0;
      model_reset();
      @(posedge clk);
      #1;
      repeat (3) cycle();
      rst = 1;

      // T2: both requesters held valid with a zero-wait memory
      ifu_addr = 32'h1000; lsu_addr = 32'h2000;
      mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'hA5A5_0001;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (ifu_req_ready) grants.push_back(0);
         if (lsu_req_ready) grants.push_back(1);
         cycle();
      end
      chk("t2_ngrant", grants.size(), 5);
      for (int i = 0; i < 4; i++) chk("t2_order", (grants.size() > i) ? grants[i] : -1, i % 2);
      quiet(3);

      // T1: IFU fetch, response three cycles after acceptance
      ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
      #1 chk("t1_rdy", ifu_req_ready, 1);
      cycle();
      ifu_req_valid = 0;
      #1 chk("t1_mreq", {mem_req_valid, mem_wen, mem_wmask}, {1'b1, 1'b0, 8'h0});
      chk("t1_maddr", mem_addr, 32'h8000_0000);
      cycle();
      mem_resp_valid = 1; mem_rdata = 32'hDEAD_BEEF;
      cycle();
      mem_resp_valid = 0; mem_rdata = 32'h0;
      #1 chk("t1_resp", {ifu_resp_valid, ifu_resp_err, ifu_resp_data}, {1'b1, 1'b0, 32'hDEAD_BEEF});
      cycle();
      quiet(2);

      // T3: LSU store returns data 0 even though memory drives rdata
      lsu_req_valid = 1; lsu_addr = 32'h8000_0004; lsu_wen = 1;
      lsu_wdata = 32'h1234_5678; lsu_wmask = 8'b0000_1100; mem_req_ready = 1;
      cycle();
      lsu_req_valid = 0;
      #1 chk("t3_mfields", {mem_req_valid, mem_wen, mem_wmask, mem_wdata},
                           {1'b1, 1'b1, 8'b0000_1100, 32'h1234_5678});
      chk("t3_maddr", mem_addr, 32'h8000_0004);
      cycle();
      mem_resp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
      cycle();
      mem_resp_valid = 0;
      #1 chk("t3_resp", {lsu_resp_valid, lsu_resp_err, lsu_resp_data}, {1'b1, 1'b0, 32'h0});
      cycle();
      lsu_wen = 0;
      quiet(2);

      // T4: downstream stalls for three cycles
      ifu_req_valid = 1; ifu_addr = 32'h8000_0040; mem_req_ready = 0;
      cycle();
      ifu_req_valid = 0;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         #1 if (mem_req_valid && mem_addr == 32'h8000_0040) cnt++;
         cycle();
      end
      mem_req_ready = 1;
      #1 if (mem_req_valid && mem_addr == 32'h8000_0040) cnt++;
      cycle();
      mem_req_ready = 0;
      chk("t4_stable", cnt, 4);
      mem_resp_valid = 1; mem_rdata = 32'h0BAD_F00D;
      cycle();
      mem_resp_valid = 0;
      #1 chk("t4_resp", {ifu_resp_valid, ifu_resp_data}, {1'b1, 32'h0BAD_F00D});
      cycle();
      quiet(2);

      // T5: memory accepts but never answers; watchdog fires, late strobes are dropped
      lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wen = 0; mem_req_ready = 1;
      cycle();
      lsu_req_valid = 0;
      found = 0; lat = -1;
      for (int k = 1; k <= 20 && !found; k++) begin
         #1;
         if (lsu_resp_valid) begin
            found = 1;
            lat = k;
            chk("t5_err", {lsu_resp_err, lsu_resp_data}, {1'b1, 32'h0});
         end
         cycle();
      end
      chk("t5_latency", lat, TMO + 1);
      mem_req_ready = 0;
      mem_resp_valid = 1; mem_rdata = 32'h7777_7777;
      repeat (3) cycle();
      quiet(2);

      // T6: reset while waiting for memory aborts the transaction silently
      ifu_req_valid = 1; ifu_addr = 32'h8000_0200; mem_req_ready = 1;
      cycle();
      cycle();
      mem_req_ready = 0; lsu_req_valid = 1;
      rst = 0;
      #1 chk("t6_rdy", {ifu_req_ready, lsu_req_ready, mem_req_valid}, 0);
      chk("t6_resp", {ifu_resp_valid, lsu_resp_valid, ifu_resp_data, lsu_resp_data}, 0);
      mem_resp_valid = 1;
      repeat (3) cycle();
      mem_resp_valid = 0;
      rst = 1;
      #1 chk("t6_first", {ifu_req_ready, lsu_req_ready}, 2'b10);
      cycle();
      quiet(TMO + 4);

      // random traffic with varying downstream behaviour
      for (int ph = 0; ph < 4; ph++) begin
         for (int i = 0; i < 600; i++) begin
            ifu_req_valid  = ($urandom_range(0, 1) == 1);
            lsu_req_valid  = ($urandom_range(0, 1) == 1);
            ifu_addr       = $urandom;
            lsu_addr       = $urandom;
            lsu_wen        = ($urandom_range(0, 1) == 1);
            lsu_wdata      = $urandom;
            lsu_wmask      = 8'($urandom);
            mem_rdata      = $urandom;
            mem_req_ready  = ($urandom_range(0, 99) < (ph == 0 ? 100 : ph == 1 ? 50 : ph == 2 ? 12 : 0));
            mem_resp_valid = ($urandom_range(0, 99) < (ph == 0 ? 100 : ph == 1 ? 30 : ph == 2 ? 10 : 0));
            cycle();
         end
      end
      quiet(TMO + 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
